// File: rtl/bsr_pkg.sv
// Shared definitions for the bidirectional shift-register serializer/deserializer pair.
package bsr_pkg;

    localparam logic MODE_LSB_FIRST    = 1'b0;
    localparam logic MODE_MSB_FIRST    = 1'b1;
    localparam int   BSR_DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } bsr_out_state_e;

    function automatic int bsr_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bsr_bit_counter.sv
// Bit position counter shared by the serializer and deserializer control paths.
module bsr_bit_counter
    import bsr_pkg::*;
#(
    parameter  int WIDTH = BSR_DEFAULT_WIDTH,
    localparam int CW    = bsr_cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          busy,
    output logic          last
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q;

    assign last = (cnt_q == CW'(WIDTH - 1));

    // Wrap is explicit so non-power-of-two widths behave the same as powers of two.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign cnt  = cnt_q;
    assign busy = busy_q;

endmodule

// File: rtl/bsr_sipo_deser.sv
// Serial-in/parallel-out receive stage: assembles words MSB- or LSB-first and
// offers them on a valid/ready port with sticky overrun on dropped words.
module bsr_sipo_deser
    import bsr_pkg::*;
#(
    parameter  int WIDTH = BSR_DEFAULT_WIDTH,
    localparam int CW    = bsr_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             mode,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun
);

    bsr_out_state_e   state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             mode_lat_q, mode_lat_d;
    logic             overrun_q, overrun_d;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             first_bit;
    logic             eff_mode;
    logic             word_done;
    logic [WIDTH-1:0] shifted;

    bsr_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (sin_en),
        .clr  (clear),
        .cnt  (cnt),
        .busy (busy),
        .last (last)
    );

    assign first_bit = (cnt == '0);
    assign eff_mode  = first_bit ? mode : mode_lat_q;
    assign word_done = sin_en & last;
    assign shifted   = eff_mode ? {sh_q[WIDTH-2:0], sin} : {sin, sh_q[WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        pout_d     = pout_q;
        mode_lat_d = mode_lat_q;
        overrun_d  = overrun_q;
        if (clear) begin
            state_d    = ST_EMPTY;
            sh_d       = '0;
            pout_d     = '0;
            mode_lat_d = MODE_MSB_FIRST;
            overrun_d  = 1'b0;
        end else begin
            if (sin_en) begin
                if (first_bit) mode_lat_d = mode;
                sh_d = word_done ? '0 : shifted;
            end
            // A word completing while the held one is accepted replaces it without loss.
            case (state_q)
                ST_EMPTY: begin
                    if (word_done) begin
                        state_d = ST_FULL;
                        pout_d  = shifted;
                    end
                end
                ST_FULL: begin
                    if (word_done) begin
                        if (pout_ready) pout_d = shifted;
                        else            overrun_d = 1'b1;
                    end else if (pout_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            sh_q       <= '0;
            pout_q     <= '0;
            mode_lat_q <= MODE_MSB_FIRST;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            pout_q     <= pout_d;
            mode_lat_q <= mode_lat_d;
            overrun_q  <= overrun_d;
        end
    end

    assign pout       = pout_q;
    assign pout_valid = (state_q == ST_FULL);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_bsr_sipo_deser.sv
// Self-checking bench for bsr_sipo_deser at WIDTH=4: directed scenarios,
// loopback sweep and randomized traffic against a word-level model.
module tb_bsr_sipo_deser;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         mode = 1'b1;
    logic         sin = 1'b0;
    logic         sin_en = 1'b0;
    logic [W-1:0] pout;
    logic         pout_valid;
    logic         pout_ready = 1'b0;
    logic         busy;
    logic         overrun;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    bsr_sipo_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .mode       (mode),
        .sin        (sin),
        .sin_en     (sin_en),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic m);
        sin = b; mode = m; sin_en = 1'b1;
        step();
        sin_en = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic m);
        for (int i = 0; i < W; i++) send_bit(m ? w[W-1-i] : w[i], m);
    endtask

    task automatic do_clear();
        clear = 1'b1; pout_ready = 1'b0; sin_en = 1'b0;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        chk_cnt++;
        if ({pout, pout_valid, busy, overrun} !== {4'b0000, 3'b000})
            $display("FAIL reset_state: got pout=%b v=%b busy=%b ovr=%b, want all 0", pout, pout_valid, busy, overrun);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_msb_first();
        logic [W-1:0] bits;
        bits = 4'b1011;
        do_clear();
        for (int i = 0; i < W; i++) begin
            send_bit(bits[W-1-i], 1'b1);
            chk_cnt++;
            if (busy !== (i < W - 1))
                $display("FAIL msb_busy_%0d: got %b, want %b", i, busy, (i < W - 1));
            else pass_cnt++;
        end
        chk_cnt++;
        if (pout !== 4'b1011 || pout_valid !== 1'b1)
            $display("FAIL msb_word: got pout=%b v=%b, want 1011 v=1", pout, pout_valid);
        else pass_cnt++;
    endtask

    task automatic test_lsb_accept();
        do_clear();
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        chk_cnt++;
        if (pout !== 4'b1101 || pout_valid !== 1'b1)
            $display("FAIL lsb_word: got pout=%b v=%b, want 1101 v=1", pout, pout_valid);
        else pass_cnt++;
        pout_ready = 1'b1;
        step();
        pout_ready = 1'b0;
        chk_cnt++;
        if (pout !== 4'b1101 || pout_valid !== 1'b0)
            $display("FAIL lsb_accept: got pout=%b v=%b, want 1101 v=0", pout, pout_valid);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        do_clear();
        send_word(4'b1011, 1'b1);
        send_word(4'b0110, 1'b1);
        chk_cnt++;
        if (overrun !== 1'b1 || pout !== 4'b1011 || pout_valid !== 1'b1)
            $display("FAIL overrun_set: got ovr=%b pout=%b v=%b, want 1 1011 1", overrun, pout, pout_valid);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (overrun !== 1'b1)
            $display("FAIL overrun_sticky: got %b, want 1", overrun);
        else pass_cnt++;
        clear = 1'b1; pout_ready = 1'b1;
        step();
        clear = 1'b0; pout_ready = 1'b0;
        chk_cnt++;
        if (overrun !== 1'b0 || pout_valid !== 1'b0)
            $display("FAIL overrun_clear: got ovr=%b v=%b, want 0 0", overrun, pout_valid);
        else pass_cnt++;
    endtask

    task automatic test_simul_accept();
        do_clear();
        send_word(4'b1011, 1'b1);
        send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
        pout_ready = 1'b1;
        send_bit(1'b0, 1'b1);
        pout_ready = 1'b0;
        chk_cnt++;
        if (pout !== 4'b0110 || pout_valid !== 1'b1 || overrun !== 1'b0)
            $display("FAIL simul_accept: got pout=%b v=%b ovr=%b, want 0110 1 0", pout, pout_valid, overrun);
        else pass_cnt++;
    endtask

    task automatic test_mode_latch();
        do_clear();
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        chk_cnt++;
        if (pout !== 4'b1011 || pout_valid !== 1'b1)
            $display("FAIL mode_latch: got pout=%b v=%b, want 1011 1", pout, pout_valid);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_clear();
        send_word(4'b1011, 1'b1);
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_cnt++;
        if (busy !== 1'b0 || pout !== 4'b0000 || pout_valid !== 1'b0)
            $display("FAIL async_reset: got busy=%b pout=%b v=%b, want 0 0000 0", busy, pout, pout_valid);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        send_word(4'b0110, 1'b1);
        chk_cnt++;
        if (pout !== 4'b0110 || pout_valid !== 1'b1)
            $display("FAIL async_reset_word: got pout=%b v=%b, want 0110 1", pout, pout_valid);
        else pass_cnt++;
    endtask

    // Upstream serializer emulated from its definition: bit i of the stream is
    // w[W-1-i] when MSB-first, w[i] when LSB-first, with random idle gaps.
    task automatic test_loopback();
        do_clear();
        for (int m = 0; m < 2; m++) begin
            for (int w = 0; w < (1 << W); w++) begin
                logic [W-1:0] wv;
                wv = W'(w);
                for (int i = 0; i < W; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send_bit((m == 1) ? wv[W-1-i] : wv[i], (m == 1));
                end
                chk_cnt++;
                if (pout !== wv || pout_valid !== 1'b1)
                    $display("FAIL loopback_m%0d_w%0d: got pout=%b v=%b, want %b 1", m, w, pout, pout_valid, wv);
                else pass_cnt++;
                pout_ready = 1'b1;
                step();
                pout_ready = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        int           nb;
        logic         wmode;
        logic         bits [W];
        logic         m_valid, m_ovr;
        logic [W-1:0] m_pout, word;
        int           errs;
        do_clear();
        nb = 0; wmode = 1'b1; m_valid = 1'b0; m_ovr = 1'b0; m_pout = '0; errs = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            sin        = 1'($urandom);
            sin_en     = ($urandom_range(0, 3) != 0);
            mode       = 1'($urandom);
            pout_ready = ($urandom_range(0, 3) == 0);
            clear      = ($urandom_range(0, 99) == 0);
            if (clear) begin
                nb = 0; m_valid = 1'b0; m_ovr = 1'b0; m_pout = '0;
            end else if (sin_en) begin
                if (nb == 0) wmode = mode;
                bits[nb] = sin;
                nb++;
                if (nb == W) begin
                    word = '0;
                    for (int i = 0; i < W; i++) begin
                        if (wmode) word[W-1-i] = bits[i];
                        else       word[i]     = bits[i];
                    end
                    nb = 0;
                    if (!m_valid || pout_ready) begin
                        m_valid = 1'b1; m_pout = word;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (m_valid && pout_ready) begin
                    m_valid = 1'b0;
                end
            end else if (m_valid && pout_ready) begin
                m_valid = 1'b0;
            end
            step();
            chk_cnt++;
            if (pout_valid !== m_valid || overrun !== m_ovr || busy !== (nb != 0)
                || (m_valid && pout !== m_pout)) begin
                if (errs < 10)
                    $display("FAIL random_cyc%0d: got v=%b ovr=%b busy=%b pout=%b, want v=%b ovr=%b busy=%b pout=%b",
                             cyc, pout_valid, overrun, busy, pout, m_valid, m_ovr, (nb != 0), m_pout);
                errs++;
            end else pass_cnt++;
        end
        sin_en = 1'b0; clear = 1'b0; pout_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_accept();
        test_overrun();
        test_simul_accept();
        test_mode_latch();
        test_async_reset();
        test_loopback();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
